// File: rtl/node_pkg.sv
// Shared types and constants for the interposer bus node.
// Ports: none (package only).
// Latency/backpressure: not applicable.
package node_pkg;

   localparam int MSG_W    = 22;
   localparam int DEST_W   = 3;
   localparam int SRC_W    = 3;
   localparam int PAY_W    = 16;
   localparam int DEST_LSB = SRC_W + PAY_W;

   localparam logic [2:0] CTRL_GRANT   = 3'b100;
   localparam logic [2:0] CTRL_RECEIVE = 3'b010;
   localparam logic [2:0] CTRL_BYPASS  = 3'b001;

   typedef struct packed {
      logic [DEST_W-1:0] dest;
      logic [SRC_W-1:0]  src;
      logic [PAY_W-1:0]  payload;
   } msg_t;

   typedef enum logic [1:0] {
      OP_IDLE,
      OP_GRANT,
      OP_RECEIVE,
      OP_BYPASS
   } op_e;

   typedef enum logic {
      INJ_PENDING,
      INJ_DONE
   } inj_state_e;

   // Anything other than an exact one-hot code (including 000) is idle.
   function automatic op_e decode_ctrl(input logic [2:0] ctrl);
      case (ctrl)
         CTRL_GRANT:   return OP_GRANT;
         CTRL_RECEIVE: return OP_RECEIVE;
         CTRL_BYPASS:  return OP_BYPASS;
         default:      return OP_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/node_tx_fifo.sv
// Per-channel transmit FIFO; head is 0 whenever the FIFO is empty.
// Ports: clk, reset (async low), push/push_dat, pop, full, empty, head.
// Latency: push visible at head one edge later; push while full drops, pop while empty is a no-op.
module node_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 22
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage needs no reset: emptiness is tracked by the pointers/count alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/node.sv
// Two-channel bus endpoint: bypass, receive/consume/forward, granted transmit, one local injection.
// Ports: clk, reset (async low), input_port {ctrl_1, ctrl_0, in_msg_1, in_msg_0},
//        output_port {req_1, req_0, out_msg_1, out_msg_0}; out_msg is combinational, req follows FIFO state.
// Backpressure: forwarded messages arriving at a full FIFO are dropped; the local injection waits for space.
module node
   import node_pkg::*;
#(
   parameter int NODE_NUMBER = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [49:0] input_port,
   output logic [51:0] output_port
);

   localparam logic [DEST_W-1:0] OWN_ADDR   = DEST_W'(NODE_NUMBER);
   localparam logic [DEST_W-1:0] LOCAL_DEST = DEST_W'((NODE_NUMBER + 2) % 8);

   logic [2:0]       ctrl     [2];
   logic [MSG_W-1:0] in_msg   [2];
   op_e              op       [2];
   logic             consume  [2];
   logic             fwd_push [2];
   logic             push     [2];
   logic             pop      [2];
   logic             full     [2];
   logic             empty    [2];
   logic [MSG_W-1:0] push_dat [2];
   logic [MSG_W-1:0] head     [2];
   logic [MSG_W-1:0] out_msg  [2];
   logic [3:0]       req      [2];

   logic [15:0]      rx_count_0;
   logic [15:0]      rx_count_1;

   inj_state_e       inj_state;
   logic [PAY_W-1:0] seq;
   msg_t             inj_msg;
   logic             inj_push;

   assign ctrl[1]   = input_port[49:47];
   assign ctrl[0]   = input_port[46:44];
   assign in_msg[1] = input_port[43:22];
   assign in_msg[0] = input_port[21:0];

   for (genvar c = 0; c < 2; c++) begin : g_ch
      assign op[c]       = decode_ctrl(ctrl[c]);
      assign consume[c]  = (op[c] == OP_RECEIVE) && (in_msg[c][DEST_LSB +: DEST_W] == OWN_ADDR);
      assign fwd_push[c] = (op[c] == OP_RECEIVE) && !consume[c];
      assign pop[c]      = (op[c] == OP_GRANT);

      node_tx_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (MSG_W)
      ) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .push     (push[c]),
         .push_dat (push_dat[c]),
         .pop      (pop[c]),
         .full     (full[c]),
         .empty    (empty[c]),
         .head     (head[c])
      );

      assign out_msg[c] = (op[c] == OP_GRANT)  ? head[c]   :
                          (op[c] == OP_BYPASS) ? in_msg[c] : '0;
      assign req[c]     = empty[c] ? 4'd0 : {1'b1, head[c][DEST_LSB +: DEST_W]};
   end

   // Forwarded traffic owns the channel-0 push port; the injection only takes
   // an edge where no forward is being attempted and there is room.
   assign inj_msg     = '{dest: LOCAL_DEST, src: OWN_ADDR, payload: seq};
   assign inj_push    = (inj_state == INJ_PENDING) && !fwd_push[0] && !full[0];
   assign push[0]     = (fwd_push[0] && !full[0]) || inj_push;
   assign push_dat[0] = fwd_push[0] ? in_msg[0] : inj_msg;
   assign push[1]     = fwd_push[1] && !full[1];
   assign push_dat[1] = in_msg[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inj_state <= INJ_PENDING;
         seq       <= '0;
      end else if (inj_push) begin
         inj_state <= INJ_DONE;
         seq       <= seq + PAY_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_count_0 <= '0;
         rx_count_1 <= '0;
      end else begin
         if (consume[0]) begin
            rx_count_0 <= rx_count_0 + 16'd1;
         end
         if (consume[1]) begin
            rx_count_1 <= rx_count_1 + 16'd1;
         end
      end
   end

   // Bypass is combinational from in_msg, so outputs are forced low during reset.
   assign output_port = reset ? {req[1], req[0], out_msg[1], out_msg[0]} : '0;

endmodule

// File: tb/tb_node.sv
module tb_node;

   localparam logic [2:0] IDLE  = 3'b000;
   localparam logic [2:0] GRANT = 3'b100;
   localparam logic [2:0] RECV  = 3'b010;
   localparam logic [2:0] BYP   = 3'b001;

   typedef struct {
      logic [2:0]  c1;
      logic [2:0]  c0;
      logic [21:0] m1;
      logic [21:0] m0;
      logic [21:0] o1;
      logic [21:0] o0;
      logic [3:0]  r1;
      logic [3:0]  r0;
   } vec_t;

   localparam int NV = 12;

   logic        clk;
   logic        rst_n;
   logic [49:0] input_port;
   logic [51:0] output_port;

   int tests = 0;
   int fails = 0;

   vec_t        vt [NV];
   logic [21:0] q1 [$];
   logic [21:0] m;
   logic [21:0] exp_o;
   logic [3:0]  exp_r;

   wire [21:0] o0 = output_port[21:0];
   wire [21:0] o1 = output_port[43:22];
   wire [3:0]  r0 = output_port[47:44];
   wire [3:0]  r1 = output_port[51:48];

   node #(.NODE_NUMBER(4), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (rst_n),
      .input_port  (input_port),
      .output_port (output_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] c1, input logic [2:0] c0,
                        input logic [21:0] m1, input logic [21:0] m0);
      input_port = {c1, c0, m1, m0};
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          c1      c0      m1          m0          o1          o0          r1     r0
      vt[0]  = '{IDLE,   GRANT,  22'h0,      22'h0,      22'h0,      22'h340000, 4'h0,  4'h0};
      vt[1]  = '{RECV,   IDLE,   22'h220FF0, 22'h0,      22'h0,      22'h0,      4'h0,  4'h0};
      vt[2]  = '{BYP,    IDLE,   22'h0A0F0F, 22'h0,      22'h0A0F0F, 22'h0,      4'h0,  4'h0};
      vt[3]  = '{IDLE,   RECV,   22'h0,      22'h3A0C8F, 22'h0,      22'h0,      4'h0,  4'hF};
      vt[4]  = '{IDLE,   GRANT,  22'h0,      22'h0,      22'h0,      22'h3A0C8F, 4'h0,  4'h0};
      vt[5]  = '{IDLE,   GRANT,  22'h0,      22'h155555, 22'h0,      22'h0,      4'h0,  4'h0};
      vt[6]  = '{3'b011, 3'b110, 22'h3A0C8F, 22'h1ABCDE, 22'h0,      22'h0,      4'h0,  4'h0};
      vt[7]  = '{GRANT,  BYP,    22'h0,      22'h123456, 22'h0,      22'h123456, 4'h0,  4'h0};
      vt[8]  = '{RECV,   RECV,   22'h200001, 22'h200002, 22'h0,      22'h0,      4'h0,  4'h0};
      vt[9]  = '{RECV,   RECV,   22'h0A0F0F, 22'h1ABCDE, 22'h0,      22'h0,      4'h9,  4'hB};
      vt[10] = '{GRANT,  GRANT,  22'h0,      22'h0,      22'h0A0F0F, 22'h1ABCDE, 4'h0,  4'h0};
      vt[11] = '{3'b111, IDLE,   22'h0A0F0F, 22'h0,      22'h0,      22'h0,      4'h0,  4'h0};

      // Reset with active-looking inputs: every output must stay 0.
      rst_n = 1'b0;
      drive(BYP, GRANT, 22'h0A0F0F, 22'h155555);
      repeat (2) @(posedge clk);
      #3;
      check("reset_outputs", output_port, 52'h0);
      edge_step();
      drive(IDLE, IDLE, 22'h0, 22'h0);
      #2;
      rst_n = 1'b1;
      edge_step();
      check("inject_req0", {48'h0, r0}, {48'h0, 4'b1110});
      check("inject_req1", {48'h0, r1}, 52'h0);
      check("rx_count_0_reset", {36'h0, dut.rx_count_0}, 52'h0);

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].c1, vt[i].c0, vt[i].m1, vt[i].m0);
         #1;
         check($sformatf("vec%0d_out1", i), {30'h0, o1}, {30'h0, vt[i].o1});
         check($sformatf("vec%0d_out0", i), {30'h0, o0}, {30'h0, vt[i].o0});
         edge_step();
         check($sformatf("vec%0d_req1", i), {48'h0, r1}, {48'h0, vt[i].r1});
         check($sformatf("vec%0d_req0", i), {48'h0, r0}, {48'h0, vt[i].r0});
      end
      check("rx_count_1", {36'h0, dut.rx_count_1}, 52'd2);
      check("rx_count_0", {36'h0, dut.rx_count_0}, 52'd1);

      // Overflow ch1: five forwards, no grants; the fifth must be dropped.
      for (int i = 0; i < 5; i++) begin
         m = {3'd5, 3'd2, 16'(16'h1111 * (i + 1))};
         drive(RECV, IDLE, m, 22'h0);
         if (q1.size() < 4) q1.push_back(m);
         edge_step();
         exp_r = (q1.size() == 0) ? 4'h0 : {1'b1, q1[0][21:19]};
         check($sformatf("fill%0d_req1", i), {48'h0, r1}, {48'h0, exp_r});
      end
      // Drain with five grants: four in order, then empty.
      for (int i = 0; i < 5; i++) begin
         drive(GRANT, IDLE, 22'h0, 22'h0);
         #1;
         exp_o = (q1.size() == 0) ? 22'h0 : q1[0];
         check($sformatf("drain%0d_out1", i), {30'h0, o1}, {30'h0, exp_o});
         edge_step();
         if (q1.size() != 0) void'(q1.pop_front());
         exp_r = (q1.size() == 0) ? 4'h0 : {1'b1, q1[0][21:19]};
         check($sformatf("drain%0d_req1", i), {48'h0, r1}, {48'h0, exp_r});
      end

      // Fill both channels, then reset mid-queue.
      for (int i = 0; i < 3; i++) begin
         drive(RECV, RECV, {3'd1, 3'd0, 16'(i)}, {3'd2, 3'd0, 16'(i)});
         edge_step();
      end
      check("midq_req1", {48'h0, r1}, {48'h0, 4'b1001});
      check("midq_req0", {48'h0, r0}, {48'h0, 4'b1010});
      drive(BYP, GRANT, 22'h0A0F0F, 22'h0);
      #1;
      check("midq_out0", {30'h0, o0}, {30'h0, 3'd2, 3'd0, 16'd0});
      check("midq_out1", {30'h0, o1}, {30'h0, 22'h0A0F0F});
      #1;
      rst_n = 1'b0;
      #1;
      check("midq_reset_outputs", output_port, 52'h0);
      check("midq_reset_rx1", {36'h0, dut.rx_count_1}, 52'h0);

      // First edge after release carries a forward: injection must wait one edge.
      drive(IDLE, RECV, 22'h0, 22'h3A0C8F);
      #1;
      rst_n = 1'b1;
      edge_step();
      check("retry_req0_fwd", {48'h0, r0}, {48'h0, 4'b1111});
      check("retry_req1_empty", {48'h0, r1}, 52'h0);
      drive(IDLE, IDLE, 22'h0, 22'h0);
      edge_step();
      check("retry_req0_after_inject", {48'h0, r0}, {48'h0, 4'b1111});
      drive(IDLE, GRANT, 22'h0, 22'h0);
      #1;
      check("retry_out0_first", {30'h0, o0}, {30'h0, 22'h3A0C8F});
      edge_step();
      check("retry_out0_second", {30'h0, o0}, {30'h0, 22'h340000});
      edge_step();
      check("retry_req0_drained", {48'h0, r0}, 52'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
